proc_req_arbiter: RTL and testbench

PROC_REQ_ARBITER -- requirements
Module: proc_req_arbiter

---
 rtl/proc_req_arbiter.sv | 168 ++++++++++++++++
 tb/tb_proc_req_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_req_arbiter.sv
// -----------------------------------------------------------------------------
// proc_req_arbiter
//
// Arbitrates NUM_REQ processor requesters onto a single command port that
// feeds addr_segregator_proc. One transaction is in flight at a time: the
// winner is chosen round-robin in IDLE, its command and address are captured
// on entry to BUSY and held there until the cache reports completion
// (cache_done) or the transaction is aborted after TIMEOUT BUSY cycles.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   req_rd      in   [NUM_REQ]           per-requester read request
//   req_wr      in   [NUM_REQ]           per-requester write request
//   req_addr    in   [NUM_REQ*ADDR_WID]  flattened requester addresses
//   cache_done  in   one-cycle completion pulse from the cache datapath
//   cmd_rd      out  read command (registered)
//   cmd_wr      out  write command (registered)
//   address     out  [ADDR_WID] command address (registered, held in IDLE)
//   gnt         out  [NUM_REQ] one-hot owner of the current transaction
//   ack         out  [NUM_REQ] one-cycle completion pulse to the owner
//   timeout     out  one-cycle pulse when a transaction is aborted
//   busy        out  high while in BUSY
// -----------------------------------------------------------------------------
module proc_req_arbiter #(
    parameter int ADDR_WID = 32,
    parameter int NUM_REQ  = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_rd,
    input  logic [NUM_REQ-1:0]          req_wr,
    input  logic [NUM_REQ*ADDR_WID-1:0] req_addr,
    input  logic                        cache_done,
    output logic                        cmd_rd,
    output logic                        cmd_wr,
    output logic [ADDR_WID-1:0]         address,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        timeout,
    output logic                        busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    // Final BUSY cycle count before the transaction is abandoned.
    localparam logic [3:0] TOUT_LAST = 4'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_r;
    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     owner_r;
    logic [3:0]           tout_cnt_r;

    logic [NUM_REQ-1:0]   elig_s;
    logic [2*NUM_REQ-1:0] elig_dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [IDX_W-1:0]     off_s;
    logic [IDX_W:0]       sum_s;
    logic [IDX_W-1:0]     win_idx_s;
    logic                 win_found_s;

    // Index of the lowest set bit; callers only use it when v is non-zero.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot vector with bit idx set.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin winner: rotate the eligibility vector so that bit 0 is the
    // requester at ptr, take the lowest set bit, then map the offset back.
    always_comb begin
        elig_s      = req_rd ^ req_wr;
        elig_dbl_s  = {elig_s, elig_s} >> ptr_r;
        rot_s       = elig_dbl_s[NUM_REQ-1:0];
        win_found_s = |rot_s;
        off_s       = lowest_set(rot_s);
        sum_s       = {1'b0, ptr_r} + {1'b0, off_s};
        if (sum_s >= NUM_REQ_W) begin
            win_idx_s = IDX_W'(sum_s - NUM_REQ_W);
        end else begin
            win_idx_s = IDX_W'(sum_s);
        end
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= {IDX_W{1'b0}};
            owner_r    <= {IDX_W{1'b0}};
            tout_cnt_r <= 4'd0;
            gnt        <= {NUM_REQ{1'b0}};
            ack        <= {NUM_REQ{1'b0}};
            cmd_rd     <= 1'b0;
            cmd_wr     <= 1'b0;
            address    <= {ADDR_WID{1'b0}};
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // ack and timeout are single-cycle pulses.
            ack     <= {NUM_REQ{1'b0}};
            timeout <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (win_found_s) begin
                        state_r    <= BUSY;
                        busy       <= 1'b1;
                        owner_r    <= win_idx_s;
                        tout_cnt_r <= 4'd0;
                        gnt        <= onehot(win_idx_s);
                        cmd_rd     <= req_rd[win_idx_s];
                        cmd_wr     <= req_wr[win_idx_s];
                        address    <= req_addr[win_idx_s*ADDR_WID +: ADDR_WID];
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    // A done on the last allowed cycle still counts as a
                    // normal completion, so timeout is gated by cache_done.
                    if (cache_done || (tout_cnt_r == TOUT_LAST)) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        ack     <= onehot(owner_r);
                        timeout <= ~cache_done;
                        gnt     <= {NUM_REQ{1'b0}};
                        cmd_rd  <= 1'b0;
                        cmd_wr  <= 1'b0;
                        if (owner_r == LAST_IDX) begin
                            ptr_r <= {IDX_W{1'b0}};
                        end else begin
                            ptr_r <= owner_r + IDX_W'(1);
                        end
                    end else begin
                        tout_cnt_r <= tout_cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    gnt     <= {NUM_REQ{1'b0}};
                    cmd_rd  <= 1'b0;
                    cmd_wr  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_proc_req_arbiter
//
// Directed scenarios followed by a randomized phase. A transaction-level
// reference model (owner, age in BUSY cycles, round-robin pointer) predicts
// every output each cycle; scenario-specific checks cover grant order,
// timeout latency and request stability.
// -----------------------------------------------------------------------------
module tb_proc_req_arbiter;

    localparam int AW = 32;
    localparam int NR = 4;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_rd;
    logic [NR-1:0]   req_wr;
    logic [NR*AW-1:0] req_addr;
    logic            cache_done;
    logic            cmd_rd;
    logic            cmd_wr;
    logic [AW-1:0]   address;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   ack;
    logic            timeout;
    logic            busy;

    proc_req_arbiter #(.ADDR_WID(AW), .NUM_REQ(NR), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .cache_done(cache_done), .cmd_rd(cmd_rd),
        .cmd_wr(cmd_wr), .address(address), .gnt(gnt), .ack(ack),
        .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state
    logic [NR-1:0] e_gnt = '0, e_ack = '0;
    logic          e_rd = 1'b0, e_wr = 1'b0, e_tout = 1'b0, e_busy = 1'b0;
    logic [AW-1:0] e_addr = '0;
    int            m_ptr = 0, m_owner = 0, m_age = 0;

    int            gq[$];
    logic [NR-1:0] prev_gnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predict the state after the coming edge from the inputs now applied.
    // m_age counts BUSY cycles including the current one.
    task automatic model_step();
        bit found;
        int n;
        if (rst) begin
            e_gnt = '0; e_ack = '0; e_rd = 1'b0; e_wr = 1'b0; e_addr = '0;
            e_tout = 1'b0; e_busy = 1'b0; m_ptr = 0; m_age = 0;
        end else begin
            e_ack  = '0;
            e_tout = 1'b0;
            if (!e_busy) begin
                found = 1'b0;
                for (int k = 0; k < NR; k++) begin
                    n = (m_ptr + k) % NR;
                    if (!found && (req_rd[n] != req_wr[n])) begin
                        found   = 1'b1;
                        m_owner = n;
                    end
                end
                if (found) begin
                    e_busy = 1'b1;
                    e_gnt  = NR'(1 << m_owner);
                    e_rd   = req_rd[m_owner];
                    e_wr   = req_wr[m_owner];
                    e_addr = req_addr[m_owner*AW +: AW];
                    m_age  = 1;
                end
            end else if (cache_done || (m_age == TIMEOUT)) begin
                e_ack  = NR'(1 << m_owner);
                e_tout = !cache_done;
                e_gnt  = '0; e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0;
                m_ptr  = (m_owner + 1) % NR;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic check_all();
        int gi;
        chk("gnt",     32'(gnt),     32'(e_gnt));
        chk("ack",     32'(ack),     32'(e_ack));
        chk("cmd_rd",  32'(cmd_rd),  32'(e_rd));
        chk("cmd_wr",  32'(cmd_wr),  32'(e_wr));
        chk("address", address,      e_addr);
        chk("timeout", 32'(timeout), 32'(e_tout));
        chk("busy",    32'(busy),    32'(e_busy));
        if ((gnt != '0) && (prev_gnt == '0)) begin
            gi = 0;
            for (int b = 0; b < NR; b++) if (gnt[b]) gi = b;
            gq.push_back(gi);
        end
        prev_gnt = gnt;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_addr(input int n, input logic [AW-1:0] a);
        req_addr[n*AW +: AW] = a;
    endtask

    initial begin
        int tk;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        rst = 1'b1; req_rd = '0; req_wr = '0; req_addr = '0; cache_done = 1'b0;
        cyc();
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cyc();

        // Single read from requester 1
        req_rd = 4'b0010; set_addr(1, 32'hFFFF_0000);
        cyc();
        chk("rd_gnt", 32'(gnt), 32'h2);
        chk("rd_addr", address, 32'hFFFF_0000);
        chk("rd_cmd", 32'(cmd_rd), 32'd1);
        cyc(); cyc(); cyc();
        cache_done = 1'b1;
        cyc();
        chk("rd_ack", 32'(ack), 32'h2);
        cache_done = 1'b0; req_rd = 4'b0000;
        cyc();
        // ptr is now 2: with 0,1,2 requesting, 2 wins
        req_rd = 4'b0111;
        cyc();
        chk("ptr_after_rd", 32'(gnt), 32'h4);
        cache_done = 1'b1;
        cyc();
        cache_done = 1'b0; req_rd = 4'b0000;
        cyc();

        // Round-robin with all writers, done two cycles after each grant
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        gq.delete();
        for (int n = 0; n < NR; n++) set_addr(n, 32'h1000_0000 + 32'(n));
        req_wr = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            cache_done = e_busy && (m_age == 3);
            cyc();
        end
        req_wr = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            cache_done = e_busy && (m_age == 3);
            cyc();
        end
        cache_done = 1'b0;
        chk("rr_count", 32'(gq.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < gq.size()) chk("rr_order", 32'(gq[k]), 32'(exp_order[k]));
        end

        // Timeout on requester 2 write
        req_wr = 4'b0100; set_addr(2, 32'hABCD_DCBA);
        cyc();
        chk("to_gnt", 32'(gnt), 32'h4);
        chk("to_addr", address, 32'hABCD_DCBA);
        tk = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if ((timeout === 1'b1) && (tk == 0)) tk = k;
            if (ack != '0) req_wr = 4'b0000;
        end
        chk("to_latency", 32'(tk), 32'd16);

        // Done on the 16th BUSY cycle: completion, no timeout
        req_wr = 4'b0100;
        cyc();
        repeat (15) cyc();
        cache_done = 1'b1;
        cyc();
        chk("late_done_ack", 32'(ack), 32'h4);
        chk("late_done_tout", 32'(timeout), 32'd0);
        cache_done = 1'b0; req_wr = 4'b0000;
        cyc();

        // Illegal request from requester 0
        req_rd = 4'b1001; req_wr = 4'b0001;
        cyc();
        chk("illegal_gnt", 32'(gnt), 32'h8);
        cyc();
        cache_done = 1'b1;
        cyc();
        cache_done = 1'b0; req_rd = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("illegal_never", 32'(gnt), 32'd0);
        end
        req_rd = 4'b0000; req_wr = 4'b0000;
        cyc();

        // Reset in the middle of a transaction
        req_rd = 4'b0100;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_addr", address, 32'd0);
        rst = 1'b0; req_rd = 4'b1010;
        cyc();
        chk("rst_first_gnt", 32'(gnt), 32'h2);
        cache_done = 1'b1;
        cyc();
        cache_done = 1'b0; req_rd = 4'b0000;
        cyc();

        // Stability of held command while owner inputs change
        req_rd = 4'b0001; set_addr(0, 32'h1234_5678);
        cyc();
        chk("stab_gnt", 32'(gnt), 32'h1);
        for (int k = 0; k < 6; k++) begin
            set_addr(0, $urandom);
            req_rd[0] = ~req_rd[0];
            cyc();
            chk("stab_addr", address, 32'h1234_5678);
            chk("stab_cmd", 32'(cmd_rd), 32'd1);
        end
        cache_done = 1'b1;
        cyc();
        cache_done = 1'b0; req_rd = 4'b0000;
        cyc();

        // Randomized traffic, occasional resets and long done gaps
        for (int c = 0; c < 800; c++) begin
            req_rd = 4'($urandom);
            req_wr = 4'($urandom);
            if ($urandom_range(0, 3) == 0) set_addr($urandom_range(0, NR-1), $urandom);
            if (c < 400) cache_done = ($urandom_range(0, 4) == 0);
            else         cache_done = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
